// File: rtl/muxpga_cfg_pkg.sv
// Shared types and helpers for the muxpga configuration loader.
// Holds the loader state encoding, the CRC-8 polynomial and byte/CRC helper functions.
package muxpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DONE     = 3'd5
    } cfg_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Number of host bytes needed to carry a chain of the given length.
    function automatic int cfg_bytes(input int bits);
        return (bits + 32'sd7) / 32'sd8;
    endfunction

    // One MSB-first step of CRC-8 with the loader polynomial.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb_s;
        fb_s = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb_s ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/muxpga_cfg_crc8.sv
// Serial CRC-8 accumulator: one bit per enable, cleared at the start of a load.
module muxpga_cfg_crc8
    import muxpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // CRC register: clear has priority over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= 8'h00;
        end else if (clr) begin
            crc_r <= 8'h00;
        end else if (en) begin
            crc_r <= crc8_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/muxpga_cfg_loader.sv
// Byte-to-serial config chain streamer for the muxpga fabric (cfg_clk/cfg_data/cfg_latch).
// Optional trailing CRC-8 check of the shifted bits is built when MUXPGA_CFG_CRC_EN is defined.
module muxpga_cfg_loader
    import muxpga_cfg_pkg::*;
#(
    parameter int CFG_BITS = 64,
    parameter int DIV      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_clk,
    output logic       cfg_data,
    output logic       cfg_latch,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int BIT_W = $clog2(cfg_bytes(CFG_BITS) * 8 + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    cfg_state_e       state_r;
    logic [7:0]       shreg_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             in_ready_r;
    logic             cfg_clk_r;
    logic             cfg_data_r;
    logic             cfg_latch_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic             div_last_s;
    logic [BIT_W-1:0] next_bit_s;
    logic             chain_full_s;
    logic             byte_end_s;

    assign div_last_s   = (div_cnt_r == DIV_W'(DIV - 1));
    assign next_bit_s   = bit_cnt_r + BIT_W'(1);
    assign chain_full_s = (next_bit_s == BIT_W'(CFG_BITS));
    assign byte_end_s   = (bit_cnt_r[2:0] == 3'd7);

`ifdef MUXPGA_CFG_CRC_EN
    logic       crc_clr_s;
    logic       crc_en_s;
    logic [7:0] crc_s;

    // A bit enters the CRC at the same moment it is committed to the chain.
    assign crc_clr_s = (state_r == ST_IDLE) && start;
    assign crc_en_s  = (state_r == ST_SHIFT_HI) && div_last_s;

    muxpga_cfg_crc8 u_crc8 (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr_s),
        .en     (crc_en_s),
        .bit_in (shreg_r[7]),
        .crc    (crc_s)
    );
`endif

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shreg_r     <= 8'h00;
            bit_cnt_r   <= '0;
            div_cnt_r   <= '0;
            in_ready_r  <= 1'b0;
            cfg_clk_r   <= 1'b0;
            cfg_data_r  <= 1'b0;
            cfg_latch_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            cfg_latch_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_FETCH;
                        busy_r     <= 1'b1;
                        err_r      <= 1'b0;
                        bit_cnt_r  <= '0;
                        in_ready_r <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (in_valid) begin
                        in_ready_r <= 1'b0;
`ifdef MUXPGA_CFG_CRC_EN
                        // A full chain count here means this byte is the CRC, not payload.
                        if (bit_cnt_r == BIT_W'(CFG_BITS)) begin
                            if (in_data == crc_s) begin
                                state_r <= ST_LATCH;
                            end else begin
                                err_r   <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        end else begin
                            shreg_r    <= in_data;
                            cfg_data_r <= in_data[7];
                            div_cnt_r  <= '0;
                            state_r    <= ST_SHIFT_LO;
                        end
`else
                        shreg_r    <= in_data;
                        cfg_data_r <= in_data[7];
                        div_cnt_r  <= '0;
                        state_r    <= ST_SHIFT_LO;
`endif
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                        cfg_clk_r <= 1'b1;
                        state_r   <= ST_SHIFT_HI;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                        cfg_clk_r <= 1'b0;
                        shreg_r   <= {shreg_r[6:0], 1'b0};
                        bit_cnt_r <= next_bit_s;
                        // Chain-full check comes first so a partial last byte drops its low bits.
                        if (chain_full_s) begin
`ifdef MUXPGA_CFG_CRC_EN
                            in_ready_r <= 1'b1;
                            state_r    <= ST_FETCH;
`else
                            state_r    <= ST_LATCH;
`endif
                        end else if (byte_end_s) begin
                            in_ready_r <= 1'b1;
                            state_r    <= ST_FETCH;
                        end else begin
                            cfg_data_r <= shreg_r[6];
                            state_r    <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                ST_LATCH: begin
                    cfg_latch_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b0;
                    cfg_clk_r  <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign cfg_clk   = cfg_clk_r;
    assign cfg_data  = cfg_data_r;
    assign cfg_latch = cfg_latch_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Directed bench for muxpga_cfg_loader: three instances (16/1, 12/2, 8/1 bits/DIV), table vectors plus reset and CRC sequences.
module tb_muxpga_cfg_loader;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] start_v;
    logic [2:0] in_valid_v;
    logic [7:0] in_data_v [3];
    logic [2:0] in_ready_v, cfg_clk_v, cfg_data_v, cfg_latch_v, busy_v, done_v, err_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    muxpga_cfg_loader #(.CFG_BITS(16), .DIV(1)) dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .in_data(in_data_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .cfg_clk(cfg_clk_v[0]),
        .cfg_data(cfg_data_v[0]), .cfg_latch(cfg_latch_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .err(err_v[0]));

    muxpga_cfg_loader #(.CFG_BITS(12), .DIV(2)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .in_data(in_data_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .cfg_clk(cfg_clk_v[1]),
        .cfg_data(cfg_data_v[1]), .cfg_latch(cfg_latch_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .err(err_v[1]));

    muxpga_cfg_loader #(.CFG_BITS(8), .DIV(1)) dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .in_data(in_data_v[2]),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .cfg_clk(cfg_clk_v[2]),
        .cfg_data(cfg_data_v[2]), .cfg_latch(cfg_latch_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .err(err_v[2]));

    // Chain-side observer: what the fabric would see on each instance.
    int          rises    [3] = '{0, 0, 0};
    int          latches  [3] = '{0, 0, 0};
    int          dones    [3] = '{0, 0, 0};
    int          viol     [3] = '{0, 0, 0};
    int          fall_cyc [3] = '{0, 0, 0};
    int          gap      [3] = '{0, 0, 0};
    logic [63:0] rxb      [3] = '{64'h0, 64'h0, 64'h0};
    logic [2:0]  pclk = 3'b000;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cfg_clk_v[i] && !pclk[i]) begin
                rises[i] <= rises[i] + 1;
                rxb[i]   <= {rxb[i][62:0], cfg_data_v[i]};
            end
            if (!cfg_clk_v[i] && pclk[i]) fall_cyc[i] <= cyc;
            if (cfg_latch_v[i]) begin
                latches[i] <= latches[i] + 1;
                gap[i]     <= cyc - fall_cyc[i];
            end
            if (done_v[i]) dones[i] <= dones[i] + 1;
            if (in_ready_v[i] && cfg_clk_v[i]) viol[i] <= viol[i] + 1;
            pclk[i] <= cfg_clk_v[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tb_crc(input logic [15:0] bits, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[7] ^ bits[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic send_byte(input int s, input logic [7:0] b);
        int t;
        in_data_v[s]  = b;
        in_valid_v[s] = 1'b1;
        t = 0;
        while (!in_ready_v[s] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("fetch_wait", 32'(t < 200), 32'd1);
        @(posedge clk);
        #1;
        in_valid_v[s] = 1'b0;
        chk("in_ready_after_hs", 32'(in_ready_v[s]), 32'd0);
    endtask

    task automatic wait_done(input int s, input int d0);
        int t;
        t = 0;
        while (dones[s] == d0 && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("done_wait", 32'(t < 400), 32'd1);
        repeat (10) @(negedge clk);
        #1;
    endtask

    typedef struct {
        int          sel;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nbytes;
        int          stall;
        bit          mid_start;
        logic [15:0] exp_bits;
        int          exp_n;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int s, r0, l0, d0, v0, t, st, sbad;
        logic [15:0] mask;
        s  = v.sel;
        r0 = rises[s]; l0 = latches[s]; d0 = dones[s]; v0 = viol[s];
        @(negedge clk);
        start_v[s] = 1'b1; in_data_v[s] = v.b0; in_valid_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        st = cyc;
        chk("busy_on_start", 32'(busy_v[s]), 32'd1);
        chk("in_ready_fetch", 32'(in_ready_v[s]), 32'd1);
        @(posedge clk);
        #1;
        in_valid_v[s] = 1'b0;
        chk("in_ready_after_hs", 32'(in_ready_v[s]), 32'd0);
        t = 0;
        while (!cfg_clk_v[s] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("first_rise_latency", 32'(cyc - st), 32'(v.exp_lat));
        if (v.mid_start) begin
            @(negedge clk); start_v[s] = 1'b1;
            @(negedge clk); start_v[s] = 1'b0;
        end
        if (v.nbytes == 2) begin
            if (v.stall > 0) begin
                t = 0;
                while (!in_ready_v[s] && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                sbad = 0;
                repeat (v.stall) begin
                    if (cfg_clk_v[s] || !in_ready_v[s]) sbad++;
                    @(negedge clk);
                end
                chk("stall_hold", 32'(sbad), 32'd0);
            end
            send_byte(s, v.b1);
        end
`ifdef MUXPGA_CFG_CRC_EN
        send_byte(s, tb_crc(v.exp_bits, v.exp_n));
`endif
        wait_done(s, d0);
        mask = (16'h1 << v.exp_n) - 16'h1;
        chk("bit_count", 32'(rises[s] - r0), 32'(v.exp_n));
        chk("bit_stream", 32'(rxb[s][15:0] & mask), 32'(v.exp_bits));
        chk("latch_count", 32'(latches[s] - l0), 32'd1);
`ifndef MUXPGA_CFG_CRC_EN
        chk("latch_gap", 32'(gap[s]), 32'd1);
`endif
        chk("done_count", 32'(dones[s] - d0), 32'd1);
        chk("busy_after", 32'(busy_v[s]), 32'd0);
        chk("err_after", 32'(err_v[s]), 32'd0);
        chk("ready_while_shift", 32'(viol[s] - v0), 32'd0);
    endtask

`ifdef MUXPGA_CFG_CRC_EN
    task automatic crc_case(input logic [7:0] crcb, input logic exp_err, input int exp_latch);
        int l0, d0;
        l0 = latches[2]; d0 = dones[2];
        @(negedge clk);
        start_v[2] = 1'b1; in_data_v[2] = 8'h01; in_valid_v[2] = 1'b1;
        @(posedge clk); #1; start_v[2] = 1'b0;
        @(posedge clk); #1; in_valid_v[2] = 1'b0;
        send_byte(2, crcb);
        wait_done(2, d0);
        chk("crc_err", 32'(err_v[2]), 32'(exp_err));
        chk("crc_latch", 32'(latches[2] - l0), 32'(exp_latch));
        chk("crc_done", 32'(dones[2] - d0), 32'd1);
    endtask
`endif

    vec_t vecs [6];

    initial begin
        int t, r0, l0, d0;
        vecs[0] = '{sel: 0, b0: 8'hA5, b1: 8'h3C, nbytes: 2, stall: 0,  mid_start: 1'b0, exp_bits: 16'hA53C, exp_n: 16, exp_lat: 2};
        vecs[1] = '{sel: 1, b0: 8'hFF, b1: 8'h9F, nbytes: 2, stall: 0,  mid_start: 1'b0, exp_bits: 16'h0FF9, exp_n: 12, exp_lat: 3};
        vecs[2] = '{sel: 0, b0: 8'hA5, b1: 8'h3C, nbytes: 2, stall: 10, mid_start: 1'b0, exp_bits: 16'hA53C, exp_n: 16, exp_lat: 2};
        vecs[3] = '{sel: 0, b0: 8'h00, b1: 8'hFF, nbytes: 2, stall: 0,  mid_start: 1'b1, exp_bits: 16'h00FF, exp_n: 16, exp_lat: 2};
        vecs[4] = '{sel: 1, b0: 8'h9F, b1: 8'hF0, nbytes: 2, stall: 3,  mid_start: 1'b0, exp_bits: 16'h09FF, exp_n: 12, exp_lat: 3};
        vecs[5] = '{sel: 2, b0: 8'h01, b1: 8'h00, nbytes: 1, stall: 0,  mid_start: 1'b0, exp_bits: 16'h0001, exp_n: 8,  exp_lat: 2};

        rst_v = 3'b111; start_v = 3'b000; in_valid_v = 3'b000;
        for (int i = 0; i < 3; i++) in_data_v[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_outputs", 32'({in_ready_v[i], cfg_clk_v[i], cfg_data_v[i], cfg_latch_v[i],
                                       busy_v[i], done_v[i], err_v[i]}), 32'd0);
        @(negedge clk);
        rst_v = 3'b000;

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Asynchronous reset in the middle of bit 5 of the first byte.
        r0 = rises[0]; l0 = latches[0]; d0 = dones[0];
        @(negedge clk);
        start_v[0] = 1'b1; in_data_v[0] = 8'hA5; in_valid_v[0] = 1'b1;
        @(posedge clk); #1; start_v[0] = 1'b0;
        @(posedge clk); #1; in_valid_v[0] = 1'b0;
        t = 0;
        while ((rises[0] - r0) < 5 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("reach_bit5", 32'(t < 100), 32'd1);
        #2;
        rst_v[0] = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({in_ready_v[0], cfg_clk_v[0], cfg_data_v[0], cfg_latch_v[0],
                                         busy_v[0], done_v[0], err_v[0]}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_v[0] = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("reset_no_latch", 32'(latches[0] - l0), 32'd0);
        chk("reset_no_done", 32'(dones[0] - d0), 32'd0);
        chk("reset_idle_busy", 32'(busy_v[0]), 32'd0);
        run_vec(vecs[0]);

`ifdef MUXPGA_CFG_CRC_EN
        crc_case(8'h00, 1'b1, 0);
        crc_case(8'h07, 1'b0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muxpga_cfg_loader.md
Name: muxpga_cfg_loader

Overview:
Host-side configuration streamer for the muxpga fabric. It accepts the configuration bitstream as bytes over a valid/ready port and serialises it MSB-first onto the fabric's config shift chain (cfg_clk/cfg_data). After the last bit it issues a one-cycle latch strobe that commits the chain. It is the writer for the fabric's config-chain receiver and sits between the host/SPI front end and the muxpga core.

Parameters:
CFG_BITS, 64, total config chain length in bits (>=1); bytes consumed = ceil(CFG_BITS/8)
DIV, 2, cfg_clk half-period in clk cycles (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load when idle
in_data  in  8  config byte, MSB shifted first
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid && in_ready
cfg_clk  out  1  chain shift clock; fabric samples cfg_data on its rising edge
cfg_data  out  1  chain serial data
cfg_latch  out  1  one-cycle commit strobe
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse at end of a load (success or error)
err  out  1  sticky error flag; cleared by next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; in_ready, cfg_clk, cfg_data, cfg_latch, busy, done, err all 0; bit/byte counters 0. A reset mid-load leaves the chain unlatched.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE: start -> FETCH, busy=1, err=0, bit count cleared. start while busy is ignored.
- FETCH: in_ready=1; on handshake, load byte into shift reg -> SHIFT_LO. in_valid low stalls indefinitely with cfg_clk=0; no timeout.
- SHIFT_LO: cfg_data=shreg[7], cfg_clk=0 for DIV cycles -> SHIFT_HI.
- SHIFT_HI: cfg_clk=1 for DIV cycles, cfg_data held; on exit, shift left and increment the bit count. If bit count == CFG_BITS -> LATCH; else if 8 bits of this byte done -> FETCH; else -> SHIFT_LO.
- Partial last byte: only its upper (CFG_BITS mod 8) bits are shifted; lower bits are discarded.
- LATCH: cfg_latch=1 for exactly one cycle, cfg_clk=0 -> DONE.
- DONE: done=1 for one cycle, busy drops the same cycle -> IDLE.
- in_ready is high only in FETCH, so one byte is accepted per fetch.
- Latency: start to first cfg_clk rise = 1 + handshake cycle + DIV. Each bit takes 2*DIV cycles. Last fall to cfg_latch = 1 cycle.
- cfg_clk, cfg_data and cfg_latch are registered outputs (glitch-free).

Optional Feature:
Macro MUXPGA_CFG_CRC_EN.
- Defined: one extra byte is fetched after the payload. This is a CRC-8 (poly 0x07, init 0x00, MSB-first) over exactly the CFG_BITS shifted bits. The extra byte is not shifted out.
- On match -> LATCH. On mismatch -> err=1, skip LATCH -> DONE (no cfg_latch).
- Not defined: no CRC byte is fetched; err stays 0.

Decomposition:
- Package muxpga_cfg_pkg holds:
  - the state enum;
  - CRC8_POLY = 8'h07;
  - a function computing bytes-needed from CFG_BITS.
- Sub-module muxpga_cfg_crc8 (serial CRC-8, bit-in/enable/clear) is instantiated only under MUXPGA_CFG_CRC_EN.

Test Plan:
- CFG_BITS=16, DIV=1, start, bytes 0xA5,0x3C with in_valid held high -> cfg_data sampled on cfg_clk rises = 1010010100111100; cfg_latch once, 1 cycle after last fall; done pulse; 16 cfg_clk rises total.
- CFG_BITS=12, bytes 0xFF,0x9F -> 12 rises, bits 1111_1111_1001; low nibble 0xF never driven.
- Drop in_valid for 10 cycles before byte 2 -> cfg_clk stays 0 during stall; resumed bit stream is unchanged; in_ready high only while waiting.
- Assert rst during bit 5 of byte 1 -> all outputs 0 immediately (async); no cfg_latch; a new start then completes normally.
- start pulsed while busy -> ignored; the in-flight load is unaffected, and there is exactly one done.
- With MUXPGA_CFG_CRC_EN, CFG_BITS=8, byte 0x01:
  - CRC byte 0x07 -> cfg_latch=1, err=0;
  - CRC byte 0x00 -> no cfg_latch, err=1, done pulse.
